// File: rtl/pc_ras.sv
// Fetch-stage program counter with a return-address stack.
// Supports inc/add/sub/jmp plus call/ret through a DEPTH-entry LIFO.
module pc_ras #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic add,
  input  logic sub,
  input  logic jmp,
  input  logic call,
  input  logic ret,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic empty,
  output logic full,
  output logic err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic err_q, err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [5:0] cmd;
  logic multi;
  logic win_ret, win_call, win_jmp;
  logic win_sub, win_add, win_inc;
  logic push;
  logic [WIDTH-1:0] pc_inc;
  logic [DW-1:0] top;
  logic [AW-1:0] push_idx, pop_idx;

  assign pc_inc = pc_q + WIDTH'(1);
  assign top = depth_q - DW'(1);
  assign push_idx = depth_q[AW-1:0];
  assign pop_idx = top[AW-1:0];

  // More than one bit set means a multi-command cycle.
  assign cmd = {ret, call, jmp, sub, add, inc};
  assign multi = |(cmd & (cmd - 6'd1));

  assign win_ret = ret;
  assign win_call = call & ~ret;
  assign win_jmp = jmp & ~ret & ~call;
  assign win_sub = sub & ~(ret | call | jmp);
  assign win_add = add & ~(ret | call | jmp | sub);
  assign win_inc = inc & ~(ret | call | jmp | sub | add);

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    depth_d = depth_q;
    err_d = 1'b0;
    push = 1'b0;
    unique case (1'b1)
      win_ret: begin
        if (state_q == S_EMPTY) begin
          err_d = 1'b1;
        end else begin
          pc_d = stack_q[pop_idx];
          depth_d = top;
          state_d = (depth_q == DW'(1)) ? S_EMPTY : S_PARTIAL;
        end
      end
      win_call: begin
        pc_d = target;
        if (state_q == S_FULL) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          depth_d = depth_q + DW'(1);
          state_d = (depth_q == DW'(DEPTH - 1)) ? S_FULL : S_PARTIAL;
        end
      end
      win_jmp: pc_d = target;
      win_sub: pc_d = pc_q - offset;
      win_add: pc_d = pc_q + offset;
      win_inc: pc_d = pc_inc;
      default: ;
    endcase
    if (multi) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      pc_q <= RESET_VEC;
      depth_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      depth_q <= depth_d;
      err_q <= err_d;
    end
  end

  // Entries above depth are dead, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[push_idx] <= pc_inc;
  end

  assign pc = pc_q;
  assign depth = depth_q;
  assign err = err_q;
  assign empty = (depth_q == '0);
  assign full = (depth_q == DW'(DEPTH));

endmodule
